// File: rtl/sensor_ultrassom_arbitro.sv
// Round-robin arbiter that shares one ultrasonic trigger/echo engine between the water and cup sensors.
// Defining SENSOR_ARB_PRIORIDADE_XICARA_EN replaces round-robin with fixed priority for the cup sensor.
module sensor_ultrassom_arbitro #(
    parameter int TRIG_CYCLES    = 500,
    parameter int TIMEOUT_CYCLES = 1500000,
    parameter int GAP_CYCLES     = 3000000,
    parameter int W              = 22
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         req_agua,
    input  logic         req_xicara,
    input  logic         echo_agua,
    input  logic         echo_xicara,
    output logic         trigger_agua,
    output logic         trigger_xicara,
    output logic         pronto_agua,
    output logic         pronto_xicara,
    output logic         timeout_agua,
    output logic         timeout_xicara,
    output logic [W-1:0] largura,
    output logic         ocupado
);

    typedef enum logic [2:0] {
        OCIOSO,
        TRIGGER,
        ESPERA_ECHO,
        MEDE,
        INTERVALO
    } estado_t;

    localparam logic [W-1:0] TRIG_FIM    = W'(TRIG_CYCLES - 1);
    localparam logic [W-1:0] ESPERA_FIM  = W'(TIMEOUT_CYCLES - 1);
    localparam logic [W-1:0] MEDE_FIM    = W'(TIMEOUT_CYCLES);
    localparam logic [W-1:0] GAP_FIM     = W'(GAP_CYCLES - 1);

    estado_t        estado;
    estado_t        prox_estado;
    logic [W-1:0]   cnt;
    logic           echo_agua_meta;
    logic           echo_agua_sync;
    logic           echo_xicara_meta;
    logic           echo_xicara_sync;
    logic           pend_agua;
    logic           pend_xicara;
    logic           ultimo;
    logic           sel;
    logic           escolha;
    logic           echo_sel;
    logic           grant;
    logic           fim_pronto;
    logic           fim_timeout;

    // escolha: 0 = agua, 1 = xicara; ultimo starts at xicara so agua wins the first tie
`ifdef SENSOR_ARB_PRIORIDADE_XICARA_EN
    assign escolha = pend_xicara;
`else
    assign escolha = (pend_agua && pend_xicara) ? ~ultimo : pend_xicara;
`endif

    assign echo_sel = sel ? echo_xicara_sync : echo_agua_sync;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= prox_estado;
        end
    end

    always_comb begin
        prox_estado = estado;
        grant       = 1'b0;
        fim_pronto  = 1'b0;
        fim_timeout = 1'b0;
        case (estado)
            OCIOSO: begin
                if (pend_agua || pend_xicara) begin
                    grant       = 1'b1;
                    prox_estado = TRIGGER;
                end
            end
            TRIGGER: begin
                if (cnt == TRIG_FIM) begin
                    prox_estado = ESPERA_ECHO;
                end
            end
            ESPERA_ECHO: begin
                if (echo_sel) begin
                    prox_estado = MEDE;
                end else if (cnt == ESPERA_FIM) begin
                    fim_timeout = 1'b1;
                    prox_estado = INTERVALO;
                end
            end
            MEDE: begin
                if (!echo_sel) begin
                    fim_pronto  = 1'b1;
                    prox_estado = INTERVALO;
                end else if (cnt >= MEDE_FIM) begin
                    fim_timeout = 1'b1;
                    prox_estado = INTERVALO;
                end
            end
            INTERVALO: begin
                if (cnt == GAP_FIM) begin
                    prox_estado = OCIOSO;
                end
            end
            default: prox_estado = OCIOSO;
        endcase
    end

    always_comb begin
        trigger_agua   = (estado == TRIGGER) && !sel;
        trigger_xicara = (estado == TRIGGER) && sel;
        ocupado        = (estado != OCIOSO);
    end

    // A req on the grant cycle re-arms its own pending bit, so set wins over clear
    always_ff @(posedge clock) begin
        if (reset) begin
            echo_agua_meta   <= 1'b0;
            echo_agua_sync   <= 1'b0;
            echo_xicara_meta <= 1'b0;
            echo_xicara_sync <= 1'b0;
            pend_agua        <= 1'b0;
            pend_xicara      <= 1'b0;
            ultimo           <= 1'b1;
            sel              <= 1'b0;
            cnt              <= '0;
            largura          <= '0;
            pronto_agua      <= 1'b0;
            pronto_xicara    <= 1'b0;
            timeout_agua     <= 1'b0;
            timeout_xicara   <= 1'b0;
        end else begin
            echo_agua_meta   <= echo_agua;
            echo_agua_sync   <= echo_agua_meta;
            echo_xicara_meta <= echo_xicara;
            echo_xicara_sync <= echo_xicara_meta;
            pend_agua        <= req_agua | (pend_agua & ~(grant & ~escolha));
            pend_xicara      <= req_xicara | (pend_xicara & ~(grant & escolha));
            pronto_agua      <= fim_pronto & ~sel;
            pronto_xicara    <= fim_pronto & sel;
            timeout_agua     <= fim_timeout & ~sel;
            timeout_xicara   <= fim_timeout & sel;
            if (grant) begin
                sel    <= escolha;
                ultimo <= escolha;
            end
            if (fim_pronto) begin
                largura <= cnt;
            end
            if (estado != prox_estado) begin
                cnt <= (prox_estado == MEDE) ? W'(1) : '0;
            end else if (estado != OCIOSO && cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/sensor_ultrassom_arbitro.md
Name: sensor_ultrassom_arbitro

Overview:
- Shares one ultrasonic measurement engine (trigger pulse generator plus echo-width counter) between the water-level sensor and the cup-presence sensor of the cafeteira datapath.
- Queues measurement requests from the control unit and serves them round-robin, one at a time.
- Enforces a dead time between measurements to avoid acoustic crosstalk.
- Returns the echo width in clock cycles, or a timeout, to the requester.

Parameters:
TRIG_CYCLES, 500, trigger pulse length in clocks (10 us at 50 MHz)
TIMEOUT_CYCLES, 1500000, max wait for echo rise, and max echo width (30 ms)
GAP_CYCLES, 3000000, dead time after each measurement (60 ms)
W, 22, width of cycle counter and largura; must hold max(TIMEOUT_CYCLES, GAP_CYCLES)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
req_agua  in  1  single-cycle pulse: request water measurement
req_xicara  in  1  single-cycle pulse: request cup measurement
echo_agua  in  1  asynchronous echo from water sensor
echo_xicara  in  1  asynchronous echo from cup sensor
trigger_agua  out  1  trigger to water sensor
trigger_xicara  out  1  trigger to cup sensor
pronto_agua  out  1  1-cycle pulse: water measurement valid on largura
pronto_xicara  out  1  1-cycle pulse: cup measurement valid on largura
timeout_agua  out  1  1-cycle pulse: water measurement failed
timeout_xicara  out  1  1-cycle pulse: cup measurement failed
largura  out  W  echo width in clocks; held until the next pronto
ocupado  out  1  high in every state except OCIOSO

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high.
- Reset values: all outputs 0; pending bits cleared; last-served pointer = xicara, so agua wins the first tie; state OCIOSO.
- Echo synchronisation: each echo passes through a 2-flop synchronizer. All echo references below mean the synchronised signal, which lags the pin by 2 cycles.
- Pending bits: a req pulse sets the matching pending bit in any state. A pulse while the bit is already set is merged (no count). The bit clears on the cycle the grant leaves OCIOSO.
- Request during own service: a req for the sensor currently being measured sets pending again, so a fresh measurement runs after GAP.
- Arbitration (OCIOSO):
  - Only one pending: grant it.
  - Both pending: grant the one not served last.
  - Update last-served on grant, clear the cycle counter, go to TRIGGER.
  - A request arriving in OCIOSO is granted on the following cycle.
- TRIGGER: the selected trigger output is high for exactly TRIG_CYCLES cycles, then ESPERA_ECHO with counter cleared. The other trigger output stays 0 at all times.
- ESPERA_ECHO:
  - Selected echo = 1: go to MEDE, counter = 1.
  - Else, counter reaching TIMEOUT_CYCLES-1: pulse the selected timeout output, go to INTERVALO.
- MEDE:
  - Counter increments every cycle while echo = 1.
  - On echo = 0: largura <= counter, pulse the selected pronto output, go to INTERVALO.
  - Counter reaching TIMEOUT_CYCLES with echo still high: timeout pulse, largura unchanged, go to INTERVALO.
- INTERVALO: wait GAP_CYCLES cycles, then OCIOSO. An echo still high at this point is ignored.
- Output timing: pronto and timeout pulses are registered, exactly 1 cycle wide, mutually exclusive, and fire at most once per grant.
- Reset mid-operation: on the next edge, triggers drop to 0, the in-progress measurement is discarded (no pronto/timeout), and pending requests are lost.
- Counter: saturates at its terminal value and never wraps.

Optional Feature:
- Macro: SENSOR_ARB_PRIORIDADE_XICARA_EN.
- Defined: fixed priority. When both are pending, xicara is always granted first; the last-served pointer is unused.
- Undefined: round-robin as above.
- Purpose: lets the team prioritise the cup-safety check at compile time.

Test Plan (TRIG_CYCLES=4, TIMEOUT_CYCLES=100, GAP_CYCLES=10):
1. req_agua pulse in OCIOSO; echo_agua high 37 cycles after trigger falls -> trigger_agua high 4 cycles, pronto_agua 1 pulse, largura=37, trigger_xicara never high.
2. req_xicara with echo_xicara held low -> timeout_xicara pulse exactly 100 cycles after entering ESPERA_ECHO; no pronto; largura unchanged; ocupado drops 10 cycles later.
3. req_agua and req_xicara on the same cycle, repeated 3 times -> grants agua, xicara, agua, xicara, agua, xicara. With SENSOR_ARB_PRIORIDADE_XICARA_EN defined, xicara is served first each time.
4. Echo stuck high -> timeout after count 100 in MEDE; next grant starts only after 10 GAP cycles.
5. req_agua pulsed twice during its own measurement -> exactly one extra water measurement after GAP.
6. reset asserted mid-TRIGGER with req_xicara pending -> next cycle: all outputs 0, OCIOSO, no later grant for xicara.
